// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
//
// PS/2 device-to-host frame receiver. Conditions the raw ps2_clk / ps2_data
// lines (2-flop synchroniser + run-length glitch filter), detects falling
// edges of the filtered clock, and deserialises 11-bit frames:
// start(0), 8 data bits LSB first, odd parity, stop(1).
//
// Ports
//   clk           in   main clock (16 MHz nominal)
//   reset         in   synchronous, active-low
//   ps2_clk       in   PS/2 clock line (read only)
//   ps2_data      in   PS/2 data line (read only)
//   rx_enable     in   1 = receive allowed, 0 = transmitter owns the bus
//   rx_data       out  last byte that passed all checks
//   rx_valid      out  one-cycle strobe: good frame, rx_data updated
//   rx_busy       out  high while a frame is in progress
//   parity_error  out  one-cycle strobe: parity check failed
//   frame_error   out  one-cycle strobe: stop bit was 0
//   rx_timeout    out  one-cycle strobe: in-frame gap too long
//   dbg_state     out  current receive FSM state (debug observation)
//
// Handshake: results are push-only strobes. rx_valid qualifies rx_data for
// exactly one cycle; there is no ready/backpressure, the consumer must take
// the byte in that cycle. At most one of the four strobes is high per cycle.
// ---------------------------------------------------------------------------
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 32000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_enable,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       parity_error,
  output logic       frame_error,
  output logic       rx_timeout,
  output logic [1:0] dbg_state
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int GW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Line conditioning. Index 0 = ps2_clk, index 1 = ps2_data.
  // -------------------------------------------------------------------------
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          filt_q, filt_d;
  logic [1:0][FCW-1:0] fcnt_q, fcnt_d;
  logic                clk_prev_q;
  logic                fall;
  logic                data_bit;

  // The filtered value only moves after FILTER_LEN consecutive synchronised
  // samples disagree with it; any agreeing sample restarts the run.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FCW'(FILTER_LEN - 1)) begin
          filt_d[i] = sync2_q[i];
          fcnt_d[i] = '0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + 1'b1;
        end
      end else begin
        fcnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      fcnt_q     <= '0;
      clk_prev_q <= 1'b1;
    end else begin
      sync1_q    <= {ps2_data, ps2_clk};
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      clk_prev_q <= filt_q[0];
    end
  end

  assign fall     = clk_prev_q & ~filt_q[0];
  assign data_bit = filt_q[1];

  // -------------------------------------------------------------------------
  // Frame FSM
  // -------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          par_q, par_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          tout_q, tout_d;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    gap_d     = gap_q;
    rx_data_d = rx_data_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    tout_d    = 1'b0;

    if (!rx_enable) begin
      // Transmitter owns the bus: abandon any frame, emit nothing.
      state_d = S_IDLE;
      gap_d   = '0;
    end else begin
      if (state_q == S_IDLE || fall) begin
        gap_d = '0;
      end else begin
        gap_d = gap_q + 1'b1;
      end

      // gap_q counts cycles since the last fall took effect, so the strobe
      // lands exactly TIMEOUT_CYCLES clocks after that fall.
      if (state_q != S_IDLE && !fall && gap_q == GW'(TIMEOUT_CYCLES - 1)) begin
        tout_d  = 1'b1;
        state_d = S_IDLE;
        gap_d   = '0;
      end else if (fall) begin
        unique case (state_q)
          S_IDLE: begin
            if (!data_bit) begin
              shift_d = '0;
              cnt_d   = '0;
              state_d = S_DATA;
            end
          end
          S_DATA: begin
            shift_d[cnt_q] = data_bit;
            if (cnt_q == 3'd7) begin
              state_d = S_PARITY;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          S_PARITY: begin
            par_d   = data_bit;
            state_d = S_STOP;
          end
          S_STOP: begin
            state_d = S_IDLE;
            // A bad stop bit hides any parity problem.
            if (!data_bit) begin
              ferr_d = 1'b1;
            end else if (^{shift_q, par_q} == 1'b0) begin
              perr_d = 1'b1;
            end else begin
              valid_d   = 1'b1;
              rx_data_d = shift_q;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_q     <= 1'b0;
      gap_q     <= '0;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      gap_q     <= gap_d;
      rx_data_q <= rx_data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      tout_q    <= tout_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = valid_q;
  assign parity_error = perr_q;
  assign frame_error  = ferr_q;
  assign rx_timeout   = tout_q;
  assign rx_busy      = (state_q != S_IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
`timescale 1ns/1ps
module tb_ps2_frame_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 32000;

  localparam logic [2:0] K_VALID = 3'd0;
  localparam logic [2:0] K_PAR   = 3'd1;
  localparam logic [2:0] K_FRAME = 3'd2;
  localparam logic [2:0] K_TOUT  = 3'd3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_enable = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, parity_error, frame_error, rx_timeout;
  logic [1:0] dbg_state;

  always #31 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_enable(rx_enable), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_busy(rx_busy), .parity_error(parity_error), .frame_error(frame_error),
    .rx_timeout(rx_timeout), .dbg_state(dbg_state)
  );

  initial begin
    #(150000 * 62);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] exp_q[$];     // {kind, rx_data}
  logic [10:0] obs_q[$];
  int unsigned obs_cyc_q[$];
  logic [7:0]  last_data = 8'h00;
  int unsigned last_fall_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: record every result strobe and check exclusivity / busy.
  int          mon_n;
  logic [2:0]  mon_kind;
  always @(negedge clk) begin
    if (reset) begin
      mon_n = int'(rx_valid) + int'(parity_error) + int'(frame_error) + int'(rx_timeout);
      if (mon_n != 0) begin
        check("pulse_exclusive", mon_n, 1);
        check("busy_low_at_result", rx_busy, 0);
        mon_kind = rx_valid ? K_VALID : parity_error ? K_PAR : frame_error ? K_FRAME : K_TOUT;
        obs_q.push_back({mon_kind, rx_data});
        obs_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- reference model ----------------
  // Odd parity: total number of ones over data+parity must be odd.
  function automatic logic [2:0] frame_kind(input logic [7:0] d, input logic p, input logic s);
    if (!s) return K_FRAME;
    if ((($countones(d) + int'(p)) % 2) == 0) return K_PAR;
    return K_VALID;
  endfunction

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  // bits[0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop.
  // dis_at >= 0 drops rx_enable just before the fall of that bit.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int half, input int dis_at);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(half);
      if (i == dis_at) begin
        rx_enable = 1'b0;
        tick(1);
        check("busy_drop_on_disable", rx_busy, 0);
      end
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      tick(half);
      ps2_clk = 1'b1;
    end
    tick(half);
    ps2_data = 1'b1;
  endtask

  // Send a full frame and compare against the expected result.
  task automatic apply(input logic [7:0] d, input logic p, input logic s, input int half,
                       input logic [2:0] ek, input logic [7:0] ed, input string tag);
    clear_obs();
    exp_q.push_back({ek, ed});
    send_bits({s, p, d, 1'b0}, 11, half, -1);
    tick(20);
    check({tag, "_count"}, obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      logic [10:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_kind"}, o[10:8], e[10:8]);
      check({tag, "_data"}, o[7:0], e[7:0]);
      // Raw fall is first sampled one edge after it is driven; the result
      // then follows after 2 sync stages + FILTER_LEN filter samples.
      check({tag, "_latency"}, obs_cyc_q[0], last_fall_cyc + 3 + FILTER_LEN);
    end
    exp_q.delete();
    check({tag, "_busy_after"}, rx_busy, 0);
    check({tag, "_rx_data_after"}, rx_data, ed);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         half;
    logic [2:0] exp_kind;
    logic [7:0] exp_rx_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // Hand-derived expectations.
    vecs[0] = '{8'hFA, 1'b1, 1'b1, 640, K_VALID, 8'hFA};  // 80 us bit period
    vecs[1] = '{8'h08, 1'b1, 1'b1, 24,  K_PAR,   8'hFA};  // parity should be 0
    vecs[2] = '{8'h55, 1'b1, 1'b0, 24,  K_FRAME, 8'hFA};  // bad stop
    vecs[3] = '{8'h00, 1'b1, 1'b1, 24,  K_VALID, 8'h00};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 24,  K_PAR,   8'h00};
    vecs[5] = '{8'h8C, 1'b1, 1'b0, 30,  K_FRAME, 8'h00};  // stop beats parity
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 12,  K_VALID, 8'hFF};

    // Reset state
    reset = 1'b0;
    tick(5);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_busy", rx_busy, 0);
    check("reset_pulses", {rx_valid, parity_error, frame_error, rx_timeout}, 4'b0000);
    reset = 1'b1;
    tick(20);

    for (int i = 0; i < 7; i++) begin
      apply(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].half,
            vecs[i].exp_kind, vecs[i].exp_rx_data, $sformatf("vec%0d", i));
      last_data = vecs[i].exp_rx_data;
    end

    // Timeout: clock stops after start + 5 data bits.
    clear_obs();
    send_bits({1'b1, 1'b0, 8'hB3, 1'b0}, 6, 24, -1);
    check("timeout_busy_mid", rx_busy, 1);
    begin
      int waited = 0;
      while (obs_q.size() == 0 && waited < TIMEOUT_CYCLES + 500) begin
        tick(1);
        waited++;
      end
    end
    tick(2);
    check("timeout_count", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      check("timeout_kind", obs_q[0][10:8], K_TOUT);
      check("timeout_data_kept", obs_q[0][7:0], last_data);
      check("timeout_cycle", obs_cyc_q[0], last_fall_cyc + 3 + FILTER_LEN + TIMEOUT_CYCLES);
    end
    check("timeout_busy_after", rx_busy, 0);
    apply(8'hAA, 1'b1, 1'b1, 24, K_VALID, 8'hAA, "after_timeout");
    last_data = 8'hAA;

    // rx_enable dropped before data bit 3 falls.
    clear_obs();
    send_bits({1'b1, 1'b1, 8'h3C, 1'b0}, 11, 24, 4);
    tick(20);
    check("disabled_no_pulses", obs_q.size(), 0);
    check("disabled_busy", rx_busy, 0);
    rx_enable = 1'b1;
    tick(5);
    apply(8'hF4, 1'b0, 1'b1, 24, K_VALID, 8'hF4, "after_enable");
    last_data = 8'hF4;

    // 3-cycle low glitch on ps2_clk (with data low) in IDLE.
    clear_obs();
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    tick(3);
    ps2_clk  = 1'b1;
    begin
      logic busy_seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
        tick(1);
        busy_seen |= rx_busy;
      end
      check("glitch_busy", busy_seen, 0);
    end
    ps2_data = 1'b1;
    check("glitch_no_pulses", obs_q.size(), 0);

    // Random frames against the reference model.
    for (int n = 0; n < 16; n++) begin
      logic [7:0] d;
      logic       p, s;
      logic [2:0] k;
      d = 8'($urandom_range(0, 255));
      p = ~^d;                                   // correct odd parity
      if ($urandom_range(0, 3) == 0) p = ~p;
      s = ($urandom_range(0, 6) != 0);
      k = frame_kind(d, p, s);
      if (k == K_VALID) last_data = d;
      apply(d, p, s, $urandom_range(12, 40), k, last_data, $sformatf("rand%0d", n));
    end

    // Reset mid-frame.
    send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 5, 20, -1);
    check("reset_mid_busy_before", rx_busy, 1);
    reset = 1'b0;
    tick(1);
    check("reset_mid_rx_data", rx_data, 8'h00);
    check("reset_mid_busy", rx_busy, 0);
    check("reset_mid_pulses", {rx_valid, parity_error, frame_error, rx_timeout}, 4'b0000);
    last_data = 8'h00;
    reset = 1'b1;
    tick(20);
    apply(8'h3C, 1'b1, 1'b1, 24, K_VALID, 8'h3C, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
